// File: rtl/mult_axil_pkg.sv
// rtl/mult_axil_pkg.sv - register map, bit positions, FSM states and response codes for the multiplier
package mult_axil_pkg;

    localparam logic [31:0] OFS_CTRL   = 32'h00;
    localparam logic [31:0] OFS_OP_A   = 32'h04;
    localparam logic [31:0] OFS_OP_B   = 32'h08;
    localparam logic [31:0] OFS_STATUS = 32'h0C;
    localparam logic [31:0] OFS_RES_LO = 32'h10;
    localparam logic [31:0] OFS_RES_HI = 32'h14;

    localparam int CTRL_START  = 0;
    localparam int CTRL_SIGNED = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FINISH
    } state_e;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_OP_A,
        SEL_OP_B,
        SEL_STATUS,
        SEL_RES_LO,
        SEL_RES_HI,
        SEL_NONE
    } reg_sel_e;

    // Byte-lane bits [1:0] are ignored; every register is word aligned.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr);
        case ({addr[31:2], 2'b00})
            OFS_CTRL:   return SEL_CTRL;
            OFS_OP_A:   return SEL_OP_A;
            OFS_OP_B:   return SEL_OP_B;
            OFS_STATUS: return SEL_STATUS;
            OFS_RES_LO: return SEL_RES_LO;
            OFS_RES_HI: return SEL_RES_HI;
            default:    return SEL_NONE;
        endcase
    endfunction

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] v;
        v = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) v[i*8 +: 8] = wdata[i*8 +: 8];
        end
        return v;
    endfunction

endpackage

// File: rtl/mult_seq_core.sv
// rtl/mult_seq_core.sv - radix-2 shift-add multiplier core with sign-magnitude handling
module mult_seq_core
    import mult_axil_pkg::*;
#(
    parameter int OP_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic                    signed_i,
    input  logic [OP_WIDTH-1:0]     op_a_i,
    input  logic [OP_WIDTH-1:0]     op_b_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    res_signed_o,
    output logic [2*OP_WIDTH-1:0]   result_o
);

    localparam int PW    = 2 * OP_WIDTH;
    localparam int CNT_W = $clog2(OP_WIDTH);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d, mcand_q, mcand_d, result_q, result_d;
    logic [OP_WIDTH-1:0] mplier_q, mplier_d;
    logic               neg_q, neg_d, sgn_q, sgn_d, res_sgn_q, res_sgn_d;
    logic               a_neg, b_neg;
    logic [OP_WIDTH-1:0] a_mag, b_mag;

    // The most negative operand still fits as an unsigned magnitude.
    assign a_neg = signed_i & op_a_i[OP_WIDTH-1];
    assign b_neg = signed_i & op_b_i[OP_WIDTH-1];
    assign a_mag = a_neg ? (~op_a_i + OP_WIDTH'(1)) : op_a_i;
    assign b_mag = b_neg ? (~op_b_i + OP_WIDTH'(1)) : op_b_i;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        result_d  = result_q;
        res_sgn_d = res_sgn_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_CALC;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = PW'(a_mag);
                    mplier_d = b_mag;
                    neg_d    = a_neg ^ b_neg;
                    sgn_d    = signed_i;
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(OP_WIDTH - 1)) state_d = ST_FINISH;
            end
            ST_FINISH: begin
                result_d  = neg_q ? (~acc_q + PW'(1)) : acc_q;
                res_sgn_d = sgn_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            result_q  <= '0;
            res_sgn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            sgn_q     <= sgn_d;
            result_q  <= result_d;
            res_sgn_q <= res_sgn_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_FINISH);
    assign res_signed_o = res_sgn_q;
    assign result_o     = result_q;

endmodule

// File: rtl/mult_axil_seq.sv
// rtl/mult_axil_seq.sv - AXI4-Lite register front end for the sequential multiplier
module mult_axil_seq
    import mult_axil_pkg::*;
#(
    parameter int OP_WIDTH           = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            irq
);

    logic awready_q, awready_d, bvalid_q, bvalid_d;
    logic arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic signed_q, signed_d, irq_en_q, irq_en_d, done_q, done_d;
    logic [OP_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic wr_en, rd_en, start, busy, core_done, res_signed;
    logic [2*OP_WIDTH-1:0] core_result;
    logic [63:0] res64;
    logic [31:0] ctrl_val, c_merged, a_merged, b_merged;
    reg_sel_e wr_sel, rd_sel;
    logic unused_ok;

    assign wr_en  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_en  = arready_q & S_AXI_ARVALID;
    assign wr_sel = decode_addr(32'(S_AXI_AWADDR));
    assign rd_sel = decode_addr(32'(S_AXI_ARADDR));
    assign res64  = res_signed ? 64'($signed(core_result)) : 64'(core_result);

    always_comb begin
        ctrl_val              = '0;
        ctrl_val[CTRL_SIGNED] = signed_q;
        ctrl_val[CTRL_IRQ_EN] = irq_en_q;
    end

    assign c_merged = apply_strb(ctrl_val, S_AXI_WDATA, S_AXI_WSTRB);
    assign a_merged = apply_strb(32'(op_a_q), S_AXI_WDATA, S_AXI_WSTRB);
    assign b_merged = apply_strb(32'(op_b_q), S_AXI_WDATA, S_AXI_WSTRB);
    assign start    = wr_en && (wr_sel == SEL_CTRL) && c_merged[CTRL_START] && !busy;

    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        bvalid_d  = bvalid_q & ~S_AXI_BREADY;
        bresp_d   = bresp_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        signed_d  = signed_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        if (wr_en) begin
            bvalid_d = 1'b1;
            bresp_d  = RESP_OKAY;
            case (wr_sel)
                SEL_CTRL: begin
                    signed_d = c_merged[CTRL_SIGNED];
                    irq_en_d = c_merged[CTRL_IRQ_EN];
                    if (busy && c_merged[CTRL_START]) bresp_d = RESP_SLVERR;
                end
                SEL_OP_A: if (busy) bresp_d = RESP_SLVERR; else op_a_d = a_merged[OP_WIDTH-1:0];
                SEL_OP_B: if (busy) bresp_d = RESP_SLVERR; else op_b_d = b_merged[OP_WIDTH-1:0];
                SEL_STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_DONE]) done_d = 1'b0;
                SEL_NONE: bresp_d = RESP_SLVERR;
                default: ;
            endcase
        end
        // A completing operation outranks a simultaneous W1C.
        if (start) done_d = 1'b0;
        if (core_done) done_d = 1'b1;
    end

    always_comb begin
        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        rvalid_d  = rvalid_q & ~S_AXI_RREADY;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        if (rd_en) begin
            rvalid_d = 1'b1;
            rresp_d  = RESP_OKAY;
            rdata_d  = '0;
            case (rd_sel)
                SEL_CTRL:   rdata_d = ctrl_val;
                SEL_OP_A:   rdata_d = 32'(op_a_q);
                SEL_OP_B:   rdata_d = 32'(op_b_q);
                SEL_STATUS: begin
                    rdata_d[STAT_BUSY] = busy;
                    rdata_d[STAT_DONE] = done_q;
                end
                SEL_RES_LO: rdata_d = res64[31:0];
                SEL_RES_HI: rdata_d = res64[63:32];
                default:    rresp_d = RESP_SLVERR;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            signed_q  <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            awready_q <= awready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            signed_q  <= signed_d;
            irq_en_q  <= irq_en_d;
            done_q    <= done_d;
        end
    end

    mult_seq_core #(.OP_WIDTH(OP_WIDTH)) u_core (
        .clk_i        (ACLK),
        .rst_ni       (ARESETN),
        .start_i      (start),
        .signed_i     (c_merged[CTRL_SIGNED]),
        .op_a_i       (op_a_q),
        .op_b_i       (op_b_q),
        .busy_o       (busy),
        .done_o       (core_done),
        .res_signed_o (res_signed),
        .result_o     (core_result)
    );

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign irq           = done_q & irq_en_q;
    assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, c_merged[31:3]};

endmodule

// File: tb/tb_mult_axil_seq.sv
// tb/tb_mult_axil_seq.sv - directed self-checking bench for mult_axil_seq
module tb_mult_axil_seq;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        irq;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;

    mult_axil_seq dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .irq(irq)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc <= cyc + 1;

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit got;
        got = 0;
        resp = 2'bxx;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY && S_AXI_WREADY) begin got = 1; acc_cyc = cyc; break; end
        end
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        if (got) begin
            got = 0;
            for (int i = 0; i < 20; i++) begin
                if (S_AXI_BVALID) begin got = 1; resp = S_AXI_BRESP; break; end
                @(negedge ACLK);
            end
        end
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        if (!got) begin
            n_chk++;
            $display("FAIL write_timeout addr=%h: got no handshake, required AWREADY/BVALID", addr);
        end
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit got;
        got = 0;
        data = 'x;
        resp = 2'bxx;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_ARREADY) begin got = 1; break; end
        end
        @(posedge ACLK); #1;
        S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b1;
        if (got) begin
            got = 0;
            for (int i = 0; i < 20; i++) begin
                if (S_AXI_RVALID) begin got = 1; data = S_AXI_RDATA; resp = S_AXI_RRESP; break; end
                @(negedge ACLK);
            end
        end
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        if (!got) begin
            n_chk++;
            $display("FAIL read_timeout addr=%h: got no handshake, required ARREADY/RVALID", addr);
        end
    endtask

    task automatic wait_irq(output int lat, output bit ok);
        ok = 0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ACLK);
            if (irq) begin ok = 1; lat = cyc - acc_cyc; break; end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        repeat (3) @(negedge ACLK);
        n_chk++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, irq} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs rdata=%h irq=%b, required all 0", S_AXI_RDATA, irq);
        else n_pass++;
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        axi_read(5'h00, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL reset_ctrl: got %h required 00000000", d); else n_pass++;
        n_chk++; if (r !== 2'b00) $display("FAIL reset_rresp: got %b required 00", r); else n_pass++;
        axi_read(5'h04, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL reset_op_a: got %h required 00000000", d); else n_pass++;
        axi_read(5'h0C, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL reset_status: got %h required 00000000", d); else n_pass++;
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(5'h04, 32'hAABBCCDD, 4'hF, r);
        n_chk++; if (r !== 2'b00) $display("FAIL wstrb_bresp: got %b required 00", r); else n_pass++;
        axi_write(5'h04, 32'h00001100, 4'h2, r);
        axi_read(5'h04, d, r);
        n_chk++; if (d !== 32'hAABB11DD) $display("FAIL wstrb_merge: got %h required aabb11dd", d); else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] d;
        logic [1:0]  r;
        int lat;
        bit ok;
        axi_write(5'h04, 32'd3, 4'hF, r);
        axi_write(5'h08, 32'd5, 4'hF, r);
        axi_write(5'h00, 32'h5, 4'hF, r);
        n_chk++; if (r !== 2'b00) $display("FAIL basic_start_bresp: got %b required 00", r); else n_pass++;
        wait_irq(lat, ok);
        n_chk++; if (!ok || lat !== 34) $display("FAIL basic_latency: got %0d required 34", lat); else n_pass++;
        axi_read(5'h10, d, r);
        n_chk++; if (d !== 32'd15) $display("FAIL basic_res_lo: got %h required 0000000f", d); else n_pass++;
        n_chk++; if (r !== 2'b00) $display("FAIL basic_rresp: got %b required 00", r); else n_pass++;
        axi_read(5'h14, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL basic_res_hi: got %h required 00000000", d); else n_pass++;
        axi_read(5'h0C, d, r);
        n_chk++; if (d !== 32'h2) $display("FAIL basic_status: got %h required 00000002", d); else n_pass++;
        axi_read(5'h00, d, r);
        n_chk++; if (d !== 32'h4) $display("FAIL basic_ctrl_readback: got %h required 00000004", d); else n_pass++;
    endtask

    task automatic test_ones();
        logic [31:0] d;
        logic [1:0]  r;
        int lat;
        bit ok;
        axi_write(5'h04, 32'hFFFFFFFF, 4'hF, r);
        axi_write(5'h08, 32'hFFFFFFFF, 4'hF, r);
        axi_write(5'h00, 32'h5, 4'hF, r);
        wait_irq(lat, ok);
        axi_read(5'h14, d, r);
        n_chk++; if (!ok || d !== 32'hFFFFFFFE) $display("FAIL ones_unsigned_hi: got %h required fffffffe", d); else n_pass++;
        axi_read(5'h10, d, r);
        n_chk++; if (d !== 32'h1) $display("FAIL ones_unsigned_lo: got %h required 00000001", d); else n_pass++;
        axi_write(5'h00, 32'h7, 4'hF, r);
        wait_irq(lat, ok);
        axi_read(5'h14, d, r);
        n_chk++; if (!ok || d !== 32'h0) $display("FAIL ones_signed_hi: got %h required 00000000", d); else n_pass++;
        axi_read(5'h10, d, r);
        n_chk++; if (d !== 32'h1) $display("FAIL ones_signed_lo: got %h required 00000001", d); else n_pass++;
    endtask

    task automatic test_signed_irq();
        logic [31:0] d;
        logic [1:0]  r;
        int lat;
        bit ok;
        axi_write(5'h04, 32'hFFFFFFF9, 4'hF, r);
        axi_write(5'h08, 32'd6, 4'hF, r);
        axi_write(5'h00, 32'h7, 4'hF, r);
        wait_irq(lat, ok);
        n_chk++; if (!ok) $display("FAIL signed_irq_rise: got irq=0 required 1"); else n_pass++;
        axi_read(5'h10, d, r);
        n_chk++; if (d !== 32'hFFFFFFD6) $display("FAIL signed_res_lo: got %h required ffffffd6", d); else n_pass++;
        axi_read(5'h14, d, r);
        n_chk++; if (d !== 32'hFFFFFFFF) $display("FAIL signed_res_hi: got %h required ffffffff", d); else n_pass++;
        axi_write(5'h0C, 32'h2, 4'hF, r);
        @(negedge ACLK);
        n_chk++; if (irq !== 1'b0) $display("FAIL signed_irq_clear: got %b required 0", irq); else n_pass++;
        axi_read(5'h0C, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL signed_status_clear: got %h required 00000000", d); else n_pass++;
    endtask

    task automatic test_busy_write();
        logic [31:0] d;
        logic [1:0]  r;
        int lat;
        bit ok;
        axi_write(5'h04, 32'd4, 4'hF, r);
        axi_write(5'h08, 32'd5, 4'hF, r);
        axi_write(5'h00, 32'h5, 4'hF, r);
        axi_write(5'h04, 32'd9, 4'hF, r);
        n_chk++; if (r !== 2'b10) $display("FAIL busy_op_a_bresp: got %b required 10", r); else n_pass++;
        axi_write(5'h00, 32'h5, 4'hF, r);
        n_chk++; if (r !== 2'b10) $display("FAIL busy_start_bresp: got %b required 10", r); else n_pass++;
        axi_read(5'h04, d, r);
        n_chk++; if (d !== 32'd4) $display("FAIL busy_op_a_kept: got %h required 00000004", d); else n_pass++;
        axi_read(5'h0C, d, r);
        n_chk++; if (d !== 32'h1) $display("FAIL busy_status: got %h required 00000001", d); else n_pass++;
        wait_irq(lat, ok);
        axi_read(5'h10, d, r);
        n_chk++; if (!ok || d !== 32'd20) $display("FAIL busy_result: got %h required 00000014", d); else n_pass++;
    endtask

    task automatic test_unmapped_bresp_hold();
        logic [31:0] d;
        logic [1:0]  r;
        bit got, held, extra;
        axi_read(5'h18, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL unmapped_rdata: got %h required 00000000", d); else n_pass++;
        n_chk++; if (r !== 2'b10) $display("FAIL unmapped_rresp: got %b required 10", r); else n_pass++;
        axi_write(5'h18, 32'h1234, 4'hF, r);
        n_chk++; if (r !== 2'b10) $display("FAIL unmapped_bresp: got %b required 10", r); else n_pass++;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'd7; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge ACLK);
            if (S_AXI_AWREADY) begin got = 1; break; end
        end
        @(posedge ACLK); #1;
        S_AXI_WDATA = 32'd8;
        held = 1; extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (S_AXI_BVALID !== 1'b1) held = 0;
            if (S_AXI_AWREADY !== 1'b0) extra = 1;
        end
        n_chk++; if (!got || !held) $display("FAIL bvalid_hold: got held=%b accepted=%b required 1 1", held, got); else n_pass++;
        n_chk++; if (extra) $display("FAIL no_second_accept: got AWREADY=1 required 0"); else n_pass++;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 1'b0;
        axi_read(5'h08, d, r);
        n_chk++; if (d !== 32'd7) $display("FAIL held_op_b: got %h required 00000007", d); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic [1:0]  r;
        int t0;
        bit bad;
        axi_write(5'h04, 32'd3, 4'hF, r);
        axi_write(5'h08, 32'd5, 4'hF, r);
        axi_write(5'h00, 32'h5, 4'hF, r);
        repeat (5) @(posedge ACLK);
        #1 ARESETN = 1'b0;
        #1;
        n_chk++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
             S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, irq} !== '0)
            $display("FAIL midreset_outputs: got nonzero outputs rdata=%h irq=%b, required all 0", S_AXI_RDATA, irq);
        else n_pass++;
        repeat (3) @(posedge ACLK);
        #1 ARESETN = 1'b1;
        axi_read(5'h0C, d, r);
        n_chk++; if (d !== 32'h0) $display("FAIL midreset_status: got %h required 00000000", d); else n_pass++;
        t0 = cyc;
        bad = 0;
        while (cyc < t0 + 40) begin
            axi_read(5'h0C, d, r);
            if (d !== 32'h0) bad = 1;
        end
        n_chk++; if (bad) $display("FAIL midreset_no_done: got status %h required 00000000", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_wstrb();
        test_basic();
        test_ones();
        test_signed_irq();
        test_busy_write();
        test_unmapped_bresp_hold();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
